pc_gen: RTL and testbench
=========================

PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 Parameter ADDR_W, default 32, width of all address ports and the PC.
REQ-002 Parameter RESET_VEC, default 0, PC value held in reset and during BOOT.
REQ-003 Parameter STEP, default 1, PC increment per accepted fetch.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low (0 = reset asserted).
REQ-006 stall  input  1  pipeline stall; blocks issue of a new fetch.
REQ-007 jump  input  1  jump/branch redirect request.
REQ-008 jump_addr  input  ADDR_W  jump target.
REQ-009 trap  input  1  trap/exception redirect request, priority over jump.
REQ-010 trap_addr  input  ADDR_W  trap target.
REQ-011 fetch_ready  input  1  instruction memory accepts the current fetch.
REQ-012 pc  output  ADDR_W  fetch address, registered.
REQ-013 ce  output  1  instruction memory chip enable.
REQ-014 fetch_valid  output  1  fetch request at pc is valid.
REQ-015 redirect_pending  output  1  a redirect target is latched, awaiting handshake completion.

Function
REQ-016 States BOOT, RUN, HOLD; redirect = trap | jump; target = trap ? trap_addr : jump_addr.
REQ-017 Handshake: a fetch completes on a rising edge where fetch_valid = 1 and fetch_ready = 1.
REQ-018 BOOT: ce = 0, fetch_valid = 0, pc = RESET_VEC; unconditional transition to RUN on next edge; redirects ignored.
REQ-019 RUN: ce = 1; fetch_valid = ~stall (combinational).
REQ-020 HOLD: ce = 1; fetch_valid = 1 regardless of stall; pc stable until completion.
REQ-021 RUN, fetch_valid & ~fetch_ready: next state HOLD, pc unchanged; if redirect, pending register <= target, redirect_pending <= 1.
REQ-022 RUN, otherwise, redirect: pc <= target (overrides stall and increment), stay RUN.
REQ-023 RUN, otherwise, no redirect, fetch completes: pc <= pc + STEP.
REQ-024 RUN, stall, no redirect: pc unchanged.
REQ-025 HOLD, ~fetch_ready: pc unchanged; redirect this cycle overwrites pending register (newest wins) and sets redirect_pending.
REQ-026 HOLD, fetch_ready: pc <= target if redirect this cycle, else pending register if redirect_pending, else pc + STEP; redirect_pending <= 0; next state RUN.
REQ-027 trap and jump asserted together: trap_addr used, jump discarded.
REQ-028 pc + STEP computed modulo 2^ADDR_W (wrap from max to low addresses, no flag).
REQ-029 Targets loaded unmodified; no alignment checking.
REQ-030 fetch_valid never falls while in HOLD (request stable until accepted).

Reset
REQ-031 rst = 0 asynchronously forces: state BOOT, pc = RESET_VEC, ce = 0, fetch_valid = 0, redirect_pending = 0, pending register = 0.
REQ-032 Reset asserted mid-HOLD or mid-redirect discards all pending state; no redirect survives reset.
REQ-033 After rst rises, first edge stays in BOOT (ce = 0), then RUN with ce = 1 from the following cycle.

Verification
REQ-034 Reset release, stall = 0, fetch_ready = 1 -> ce 0 one cycle, then pc = 0,1,2,3 on successive cycles with fetch_valid = 1.
REQ-035 In RUN pc = 5, fetch_ready = 0 for 3 cycles with jump = 1, jump_addr = 0x40 in cycle 2 -> pc stays 5, redirect_pending = 1, fetch_valid = 1; on fetch_ready = 1, next pc = 0x40, redirect_pending = 0.
REQ-036 trap = 1, trap_addr = 0x100 with jump = 1, jump_addr = 0x80, stall = 1 -> next pc = 0x100.
REQ-037 ADDR_W = 8, STEP = 4, pc = 0xFC, fetch completes -> pc = 0x00.
REQ-038 In HOLD with jump pending (0x40), fetch_ready = 1 and trap = 1, trap_addr = 0x200 same cycle -> pc = 0x200.
REQ-039 rst = 0 asserted mid-cycle during HOLD -> pc = RESET_VEC, ce = 0, fetch_valid = 0, redirect_pending = 0 immediately, before next clock edge.

Source files
------------

// File: rtl/pc_gen.sv
// Program counter generator: issues fetch addresses with stall, jump/trap redirect
// and a HOLD state that keeps a not-yet-accepted fetch request stable.
module pc_gen #(
  parameter int                 ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]  RESET_VEC = '0,
  parameter int                 STEP      = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_addr,
  input  logic              trap,
  input  logic [ADDR_W-1:0] trap_addr,
  input  logic              fetch_ready,
  output logic [ADDR_W-1:0] pc,
  output logic              ce,
  output logic              fetch_valid,
  output logic              redirect_pending
);

  typedef enum logic [1:0] {BOOT, RUN, HOLD} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pc_nxt;
  logic [ADDR_W-1:0] pend_addr, pend_nxt;
  logic              pend_vld_nxt;
  logic              redirect;
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] pc_inc;

  // Trap outranks jump; the increment wraps naturally at ADDR_W bits.
  assign redirect = trap | jump;
  assign target   = trap ? trap_addr : jump_addr;
  assign pc_inc   = pc + ADDR_W'(STEP);

  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    pend_nxt     = pend_addr;
    pend_vld_nxt = redirect_pending;
    ce           = 1'b0;
    fetch_valid  = 1'b0;
    case (state)
      BOOT: begin
        pc_nxt    = RESET_VEC;
        state_nxt = RUN;
      end
      RUN: begin
        ce          = 1'b1;
        fetch_valid = !stall;
        if (!stall && !fetch_ready) begin
          // Request not accepted: freeze pc and park any redirect until the handshake.
          state_nxt = HOLD;
          if (redirect) begin
            pend_nxt     = target;
            pend_vld_nxt = 1'b1;
          end
        end else if (redirect) begin
          pc_nxt = target;
        end else if (!stall) begin
          pc_nxt = pc_inc;
        end
      end
      HOLD: begin
        ce          = 1'b1;
        fetch_valid = 1'b1;
        if (!fetch_ready) begin
          if (redirect) begin
            pend_nxt     = target;
            pend_vld_nxt = 1'b1;
          end
        end else begin
          if (redirect)              pc_nxt = target;
          else if (redirect_pending) pc_nxt = pend_addr;
          else                       pc_nxt = pc_inc;
          pend_vld_nxt = 1'b0;
          state_nxt    = RUN;
        end
      end
      default: state_nxt = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= BOOT;
      pc               <= RESET_VEC;
      pend_addr        <= '0;
      redirect_pending <= 1'b0;
    end else begin
      state            <= state_nxt;
      pc               <= pc_nxt;
      pend_addr        <= pend_nxt;
      redirect_pending <= pend_vld_nxt;
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: the driver queues the expected outputs for each
// cycle and an independent monitor compares them on the falling clock edge.
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, jump, trap, fetch_ready;
  logic [31:0] jump_addr, trap_addr;
  logic [31:0] pc;
  logic        ce, fetch_valid, redirect_pending;
  logic [7:0]  pc8;
  logic        ce8, fetch_valid8, redirect_pending8;

  always #5 clk = ~clk;

  pc_gen dut (
    .clk(clk), .rst(rst), .stall(stall), .jump(jump), .jump_addr(jump_addr),
    .trap(trap), .trap_addr(trap_addr), .fetch_ready(fetch_ready),
    .pc(pc), .ce(ce), .fetch_valid(fetch_valid), .redirect_pending(redirect_pending)
  );

  pc_gen #(.ADDR_W(8), .RESET_VEC(8'h00), .STEP(4)) dut8 (
    .clk(clk), .rst(rst), .stall(stall), .jump(jump), .jump_addr(jump_addr[7:0]),
    .trap(trap), .trap_addr(trap_addr[7:0]), .fetch_ready(fetch_ready),
    .pc(pc8), .ce(ce8), .fetch_valid(fetch_valid8), .redirect_pending(redirect_pending8)
  );

  typedef struct {
    logic        sel;
    logic [31:0] pc;
    logic        ce;
    logic        fv;
    logic        rp;
    string       name;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic j, input logic [31:0] ja,
                       input logic t, input logic [31:0] ta, input logic fr);
    stall = s; jump = j; jump_addr = ja; trap = t; trap_addr = ta; fetch_ready = fr;
  endtask

  task automatic expect_out(input logic sel, input logic [31:0] epc, input logic ece,
                            input logic efv, input logic erp, input string nm);
    exp_t e;
    e.sel = sel; e.pc = epc; e.ce = ece; e.fv = efv; e.rp = erp; e.name = nm;
    q.push_back(e);
  endtask

  // Monitor: every cycle with a queued expectation is compared.
  initial begin
    exp_t        e;
    logic [31:0] apc;
    logic        ace, afv, arp;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        if (e.sel) begin
          apc = {24'h0, pc8}; ace = ce8; afv = fetch_valid8; arp = redirect_pending8;
        end else begin
          apc = pc; ace = ce; afv = fetch_valid; arp = redirect_pending;
        end
        checks++;
        if (apc !== e.pc || ace !== e.ce || afv !== e.fv || arp !== e.rp) begin
          failures++;
          $display("FAIL %s: got pc=%h ce=%b fv=%b rp=%b, want pc=%h ce=%b fv=%b rp=%b",
                   e.name, apc, ace, afv, arp, e.pc, e.ce, e.fv, e.rp);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 1);
    repeat (2) @(posedge clk);

    tick(); drive(0, 0, 0, 0, 0, 1); expect_out(0, 32'h0, 0, 0, 0, "rst_hold");
    tick(); rst = 1'b1; drive(0, 0, 0, 0, 0, 1); expect_out(0, 32'h0, 0, 0, 0, "boot");
    // Sequential fetch after boot
    tick(); drive(0, 0, 0, 0, 0, 1); expect_out(0, 32'h0, 1, 1, 0, "run_pc0");
    tick(); drive(0, 0, 0, 0, 0, 1); expect_out(0, 32'h1, 1, 1, 0, "run_pc1");
    tick(); drive(0, 0, 0, 0, 0, 1); expect_out(0, 32'h2, 1, 1, 0, "run_pc2");
    tick(); drive(0, 0, 0, 0, 0, 1); expect_out(0, 32'h3, 1, 1, 0, "run_pc3");
    tick(); drive(1, 0, 0, 0, 0, 1); expect_out(0, 32'h4, 1, 0, 0, "stall");
    tick(); drive(0, 0, 0, 0, 0, 1); expect_out(0, 32'h4, 1, 1, 0, "after_stall");
    // Not-ready fetch at pc 5 with a jump arriving while held
    tick(); drive(0, 0, 0, 0, 0, 0);     expect_out(0, 32'h5, 1, 1, 0, "hold_enter");
    tick(); drive(0, 1, 32'h40, 0, 0, 0); expect_out(0, 32'h5, 1, 1, 0, "hold_jump");
    tick(); drive(1, 0, 0, 0, 0, 0);     expect_out(0, 32'h5, 1, 1, 1, "hold_stall_pend");
    tick(); drive(0, 0, 0, 0, 0, 1);     expect_out(0, 32'h5, 1, 1, 1, "hold_accept");
    tick(); drive(0, 0, 0, 0, 0, 1);     expect_out(0, 32'h40, 1, 1, 0, "pend_redirect");
    // Trap beats jump and stall
    tick(); drive(1, 1, 32'h80, 1, 32'h100, 1); expect_out(0, 32'h41, 1, 0, 0, "trap_jump_stall");
    tick(); drive(0, 0, 0, 0, 0, 1);            expect_out(0, 32'h100, 1, 1, 0, "trap_prio");
    // Same-cycle trap overrides a pending jump at handshake
    tick(); drive(0, 1, 32'h40, 0, 0, 0);  expect_out(0, 32'h101, 1, 1, 0, "run_jump_hold");
    tick(); drive(0, 0, 0, 1, 32'h200, 1); expect_out(0, 32'h101, 1, 1, 1, "hold_trap_accept");
    tick(); drive(0, 0, 0, 0, 0, 1);       expect_out(0, 32'h200, 1, 1, 0, "trap_over_pend");
    // Asynchronous reset in the middle of HOLD with a redirect parked
    tick(); drive(0, 1, 32'h80, 0, 0, 0); expect_out(0, 32'h201, 1, 1, 0, "hold_enter2");
    tick(); drive(0, 0, 0, 0, 0, 0);      expect_out(0, 32'h201, 1, 1, 1, "hold_pre_rst");
    tick(); drive(0, 0, 0, 0, 0, 0); #2 rst = 1'b0; expect_out(0, 32'h0, 0, 0, 0, "async_rst");
    tick(); rst = 1'b1; drive(0, 0, 0, 0, 0, 1); expect_out(0, 32'h0, 0, 0, 0, "boot2");
    tick(); drive(0, 0, 0, 0, 0, 1); expect_out(0, 32'h0, 1, 1, 0, "no_stale_redirect");
    tick(); drive(0, 0, 0, 0, 0, 1); expect_out(0, 32'h1, 1, 1, 0, "run_after_rst");
    // 8-bit instance, STEP 4: wrap from 0xFC
    tick(); drive(0, 1, 32'hFC, 0, 0, 1); expect_out(1, 32'h08, 1, 1, 0, "w8_run");
    tick(); drive(0, 0, 0, 0, 0, 1);      expect_out(1, 32'hFC, 1, 1, 0, "w8_at_fc");
    tick(); drive(0, 0, 0, 0, 0, 1);      expect_out(1, 32'h00, 1, 1, 0, "w8_wrap");
    tick(); drive(0, 0, 0, 0, 0, 1);      expect_out(1, 32'h04, 1, 1, 0, "w8_after_wrap");

    repeat (3) @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d entries left, want 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
